// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Runs one FPU operation per request through the single shared FPU input
//   mux. Operand A and then operand B are fetched by driving the mux select
//   and data inputs one after the other. The operation goes to the FPU core
//   with a valid/ready handshake. The controller then waits for the done
//   pulse and returns the result with a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_*                 request channel: opcode, unary flag, operand source
//                         codes, general-register and XMM data for A and B
//   mux_src/_rs_data/_xs_data  drive the shared input mux; mux_data is its
//                         combinational output
//   fpu_valid/ready/op/a/b     issue channel to the Q15 FPU core
//   fpu_done/fpu_result   one-cycle completion pulse and result from the core
//   resp_valid/ready/data/err  response channel; err flags an illegal source
//                         code or a completion timeout
module fpu_issue_ctrl #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int OP_W         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic            req_unary,
  input  logic [2:0]      req_a_src,
  input  logic [2:0]      req_b_src,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [63:0]     req_xs1,
  input  logic [63:0]     req_xs2,
  output logic [2:0]      mux_src,
  output logic [31:0]     mux_rs_data,
  output logic [63:0]     mux_xs_data,
  input  logic [63:0]     mux_data,
  output logic            fpu_valid,
  input  logic            fpu_ready,
  output logic [OP_W-1:0] fpu_op,
  output logic [63:0]     fpu_a,
  output logic [63:0]     fpu_b,
  input  logic            fpu_done,
  input  logic [63:0]     fpu_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [63:0]     resp_data,
  output logic            resp_err
);

  localparam int         CNT_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [2:0] SRC_MAX = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL_A,
    S_SEL_B,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;

  // Request fields still needed after the accept cycle. The A-side fields go
  // straight into the mux output registers on accept, so only B is held here.
  logic [OP_W-1:0] op_q;
  logic            unary_q;
  logic [2:0]      b_src_q;
  logic [31:0]     rs2_q;
  logic [63:0]     xs2_q;

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             timeout_hit;
  logic             req_fire;
  logic             req_illegal;

  // The counter holds at all-ones so that it never wraps back below the limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign req_fire     = req_valid && req_ready;
  // The B source code does not matter for unary ops, because B is forced to 0.
  assign req_illegal  = (req_a_src > SRC_MAX) || (!req_unary && (req_b_src > SRC_MAX));
  assign wait_cnt_nxt = sat_inc(wait_cnt);
  assign timeout_hit  = (wait_cnt_nxt == CNT_W'(WAIT_TIMEOUT));

  // All outputs are registered. The mux drive is loaded one cycle ahead, so it
  // is already valid during SEL_A and SEL_B, and mux_data is captured at the
  // end of each of those cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      op_q        <= '0;
      unary_q     <= 1'b0;
      b_src_q     <= '0;
      rs2_q       <= '0;
      xs2_q       <= '0;
      wait_cnt    <= '0;
      mux_src     <= '0;
      mux_rs_data <= '0;
      mux_xs_data <= '0;
      fpu_valid   <= 1'b0;
      fpu_op      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            op_q      <= req_op;
            unary_q   <= req_unary;
            b_src_q   <= req_b_src;
            rs2_q     <= req_rs2;
            xs2_q     <= req_xs2;
            req_ready <= 1'b0;
            if (req_illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              state      <= S_RESP;
            end else begin
              mux_src     <= req_a_src;
              mux_rs_data <= req_rs1;
              mux_xs_data <= req_xs1;
              state       <= S_SEL_A;
            end
          end
        end

        S_SEL_A: begin
          fpu_a <= mux_data;
          if (unary_q) begin
            fpu_b       <= '0;
            mux_src     <= '0;
            mux_rs_data <= '0;
            mux_xs_data <= '0;
            fpu_op      <= op_q;
            fpu_valid   <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            mux_src     <= b_src_q;
            mux_rs_data <= rs2_q;
            mux_xs_data <= xs2_q;
            state       <= S_SEL_B;
          end
        end

        S_SEL_B: begin
          fpu_b       <= mux_data;
          mux_src     <= '0;
          mux_rs_data <= '0;
          mux_xs_data <= '0;
          fpu_op      <= op_q;
          fpu_valid   <= 1'b1;
          state       <= S_ISSUE;
        end

        S_ISSUE: begin
          // Operands and opcode are only loaded on entry to ISSUE, so they stay
          // stable for as long as the FPU holds off ready.
          if (fpu_ready) begin
            fpu_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A completion beats a timeout that falls in the same cycle.
          if (fpu_done) begin
            resp_data  <= fpu_result;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt_nxt;
            if (timeout_hit) begin
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          fpu_valid  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: behavioural input mux and FPU core models,
// table-driven directed vectors, reset-in-flight sequences and random requests.
module tb_fpu_issue_ctrl;

  localparam int T    = 4;
  localparam int OP_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic            req_unary;
  logic [2:0]      req_a_src, req_b_src;
  logic [31:0]     req_rs1, req_rs2;
  logic [63:0]     req_xs1, req_xs2;
  logic [2:0]      mux_src;
  logic [31:0]     mux_rs_data;
  logic [63:0]     mux_xs_data, mux_data;
  logic            fpu_valid;
  logic            fpu_ready = 1'b0;
  logic [OP_W-1:0] fpu_op;
  logic [63:0]     fpu_a, fpu_b;
  logic            fpu_done = 1'b0;
  logic [63:0]     fpu_result = 64'h0;
  logic            resp_valid, resp_ready;
  logic [63:0]     resp_data;
  logic            resp_err;

  fpu_issue_ctrl #(.WAIT_TIMEOUT(T), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_unary(req_unary),
    .req_a_src(req_a_src), .req_b_src(req_b_src), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_xs1(req_xs1), .req_xs2(req_xs2),
    .mux_src(mux_src), .mux_rs_data(mux_rs_data), .mux_xs_data(mux_xs_data), .mux_data(mux_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Input mux model: each source code selects a fixed formatting of the data.
  function automatic logic [63:0] mux_fn(input logic [2:0] s, input logic [31:0] rs,
                                         input logic [63:0] xs);
    logic [63:0] r;
    case (s)
      3'd0:    r = 64'h0;
      3'd1:    r = {rs[15:0], 48'h0};
      3'd2:    r = xs;
      3'd3:    r = {32'h0, rs};
      3'd4:    r = ~xs;
      3'd5:    r = {rs, rs};
      default: r = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] fpu_fn(input logic [OP_W-1:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    return (a + b) ^ {{(64-OP_W){1'b0}}, op};
  endfunction

  always_comb mux_data = mux_fn(mux_src, mux_rs_data, mux_xs_data);

  // FPU core model: takes the operation after ready_delay valid cycles and
  // pulses done fpu_lat cycles after the accepting cycle.
  int              ready_delay = 0;
  int              fpu_lat = 1;
  int              cyc = 0;
  int              done_cyc = 0;
  bit              pending = 1'b0;
  logic [63:0]     pend_res = 64'h0;
  int              wcnt = 0;
  int              cap_cnt = 0;
  int              valid_cycles = 0;
  int              stab_bad = 0;
  logic [63:0]     cap_a = 64'h0, cap_b = 64'h0, hold_a = 64'h0, hold_b = 64'h0;
  logic [OP_W-1:0] cap_op = '0, hold_op = '0;

  always @(negedge clk) begin
    cyc++;
    fpu_done  = 1'b0;
    fpu_ready = 1'b0;
    if (pending && cyc == done_cyc) begin
      fpu_done   = 1'b1;
      fpu_result = pend_res;
      pending    = 1'b0;
    end
    if (fpu_valid) begin
      valid_cycles++;
      if (wcnt == 0) begin
        hold_a  = fpu_a;
        hold_b  = fpu_b;
        hold_op = fpu_op;
      end else if (fpu_a !== hold_a || fpu_b !== hold_b || fpu_op !== hold_op) begin
        stab_bad++;
      end
      if (wcnt >= ready_delay) begin
        fpu_ready = 1'b1;
        cap_a     = fpu_a;
        cap_b     = fpu_b;
        cap_op    = fpu_op;
        cap_cnt++;
        pending   = 1'b1;
        done_cyc  = cyc + fpu_lat;
        pend_res  = fpu_fn(fpu_op, fpu_a, fpu_b);
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  typedef struct {
    logic [OP_W-1:0] op;
    bit              unary;
    logic [2:0]      a_src;
    logic [2:0]      b_src;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [63:0]     xs1;
    logic [63:0]     xs2;
    int              rdy_dly;
    int              lat;
    int              resp_dly;
    bit              exp_err;
    bit              exp_issue;
    logic [63:0]     exp_a;
    logic [63:0]     exp_b;
    int              exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [OP_W-1:0] op, input bit unary,
                              input logic [2:0] a_src, input logic [2:0] b_src,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [63:0] xs1, input logic [63:0] xs2,
                              input int rdy_dly, input int lat, input int resp_dly,
                              input bit exp_err, input bit exp_issue,
                              input logic [63:0] exp_a, input logic [63:0] exp_b,
                              input int exp_lat);
    vec_t v;
    v.op = op; v.unary = unary; v.a_src = a_src; v.b_src = b_src;
    v.rs1 = rs1; v.rs2 = rs2; v.xs1 = xs1; v.xs2 = xs2;
    v.rdy_dly = rdy_dly; v.lat = lat; v.resp_dly = resp_dly;
    v.exp_err = exp_err; v.exp_issue = exp_issue; v.exp_a = exp_a; v.exp_b = exp_b;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  // Reference model for random requests, derived from the controller's rules:
  // illegal source -> error after 1 cycle; otherwise SEL_A (+SEL_B), ISSUE with
  // ready stalls, then min(latency, timeout) WAIT cycles.
  function automatic vec_t rand_vec();
    vec_t v;
    bit   bad_src;
    int   w;
    v.op       = OP_W'($urandom_range(0, 15));
    v.unary    = 1'($urandom_range(0, 1));
    v.a_src    = 3'($urandom_range(0, 7));
    v.b_src    = 3'($urandom_range(0, 7));
    v.rs1      = $urandom;
    v.rs2      = $urandom;
    v.xs1      = {$urandom, $urandom};
    v.xs2      = {$urandom, $urandom};
    v.rdy_dly  = $urandom_range(0, 3);
    v.lat      = $urandom_range(1, 7);
    v.resp_dly = $urandom_range(0, 2);
    bad_src     = (v.a_src > 3'd5) || (!v.unary && v.b_src > 3'd5);
    v.exp_issue = !bad_src;
    v.exp_err   = bad_src || (v.lat > T);
    v.exp_a     = mux_fn(v.a_src, v.rs1, v.xs1);
    v.exp_b     = v.unary ? 64'h0 : mux_fn(v.b_src, v.rs2, v.xs2);
    w           = (v.lat < T) ? v.lat : T;
    v.exp_lat   = bad_src ? 1 : ((v.unary ? 3 : 4) + v.rdy_dly + w);
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},   64'(req_ready),   64'd1);
    chk({tag, "_resp_valid"},  64'(resp_valid),  64'd0);
    chk({tag, "_fpu_valid"},   64'(fpu_valid),   64'd0);
    chk({tag, "_resp_err"},    64'(resp_err),    64'd0);
    chk({tag, "_resp_data"},   resp_data,        64'd0);
    chk({tag, "_fpu_ab_op"},   fpu_a | fpu_b | 64'(fpu_op), 64'd0);
    chk({tag, "_mux_drive"},   64'(mux_src) | 64'(mux_rs_data) | mux_xs_data, 64'd0);
  endtask

  // Presents a request at a negedge, waits for acceptance and returns at the
  // negedge of the first cycle after the accept cycle.
  task automatic start_req(input vec_t v, input string tag);
    int g;
    ready_delay = v.rdy_dly;
    fpu_lat     = v.lat;
    req_op      = v.op;
    req_unary   = v.unary;
    req_a_src   = v.a_src;
    req_b_src   = v.b_src;
    req_rs1     = v.rs1;
    req_rs2     = v.rs2;
    req_xs1     = v.xs1;
    req_xs2     = v.xs2;
    req_valid   = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_accept"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = OP_W'($urandom);
    req_unary = 1'($urandom);
    req_a_src = 3'($urandom);
    req_b_src = 3'($urandom);
    req_rs1   = $urandom;
    req_rs2   = $urandom;
    req_xs1   = {$urandom, $urandom};
    req_xs2   = {$urandom, $urandom};
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          lat, cap0, vc0, sb0;
    bit          got, rr_bad, st_bad;
    logic [63:0] rd, exp_data;
    logic        re;
    cap0 = cap_cnt;
    vc0  = valid_cycles;
    sb0  = stab_bad;
    start_req(v, tag);
    lat = 1; got = 1'b0; rr_bad = 1'b0;
    while (!got && lat < 80) begin
      if (lat == 1)
        chk({tag, "_mux_src_a"}, 64'(mux_src), v.exp_issue ? 64'(v.a_src) : 64'd0);
      if (lat == 2 && v.exp_issue)
        chk({tag, "_mux_src_b"}, 64'(mux_src), v.unary ? 64'd0 : 64'(v.b_src));
      if (resp_valid) got = 1'b1;
      else begin
        if (req_ready) rr_bad = 1'b1;
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    exp_data = v.exp_err ? 64'h0 : fpu_fn(v.op, v.exp_a, v.exp_b);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'(v.exp_err));
    chk({tag, "_resp_data"}, resp_data, exp_data);
    rd = resp_data;
    re = resp_err;
    st_bad = 1'b0;
    for (int r = 0; r < v.resp_dly; r++) begin
      resp_ready = 1'b0;
      @(negedge clk);
      if (!resp_valid || resp_data !== rd || resp_err !== re || req_ready) st_bad = 1'b1;
    end
    if (v.resp_dly > 0) chk({tag, "_resp_stall"}, 64'(st_bad), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_resp_drop"}, 64'(resp_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    chk({tag, "_busy_ready"}, 64'(rr_bad), 64'd0);
    if (v.exp_issue) begin
      chk({tag, "_issues"}, 64'(cap_cnt - cap0), 64'd1);
      chk({tag, "_fpu_a"}, cap_a, v.exp_a);
      chk({tag, "_fpu_b"}, cap_b, v.exp_b);
      chk({tag, "_fpu_op"}, 64'(cap_op), 64'(v.op));
      if (v.rdy_dly > 0) chk({tag, "_issue_stable"}, 64'(stab_bad - sb0), 64'd0);
    end else begin
      chk({tag, "_no_issue"}, 64'(valid_cycles - vc0), 64'd0);
    end
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    bit   bad;

    tbl[0] = mk(4'h1, 0, 3'b001, 3'b000, 32'h1, 32'h0, 64'h0, 64'h0, 0, 2, 0,
                0, 1, 64'h0001_0000_0000_0000, 64'h0, 6);
    tbl[1] = mk(4'h2, 1, 3'b010, 3'b111, 32'h0, 32'h0, 64'h0000_8000_0000_0000, 64'hFFFF, 0, 2, 0,
                0, 1, 64'h0000_8000_0000_0000, 64'h0, 5);
    tbl[2] = mk(4'h3, 0, 3'b110, 3'b000, 32'h5, 32'h6, 64'h7, 64'h8, 0, 2, 0,
                1, 0, 64'h0, 64'h0, 1);
    tbl[3] = mk(4'h4, 0, 3'b011, 3'b101, 32'h1234_5678, 32'hCAFE_0001, 64'h0, 64'h0, 5, 1, 3,
                0, 1, 64'h0000_0000_1234_5678, 64'hCAFE_0001_CAFE_0001, 10);
    tbl[4] = mk(4'h5, 0, 3'b100, 3'b010, 32'h0, 32'h0, 64'hFFFF_0000_FFFF_0000, 64'h1, 0, 6, 0,
                1, 1, 64'h0000_FFFF_0000_FFFF, 64'h1, 8);
    tbl[5] = mk(4'h6, 0, 3'b010, 3'b011, 32'h0, 32'h7, 64'h5, 64'h0, 0, 4, 0,
                0, 1, 64'h5, 64'h7, 8);
    tbl[6] = mk(4'h7, 0, 3'b000, 3'b111, 32'h1, 32'h2, 64'h3, 64'h4, 0, 1, 0,
                1, 0, 64'h0, 64'h0, 1);
    tbl[7] = mk(4'h8, 1, 3'b111, 3'b000, 32'h1, 32'h2, 64'h3, 64'h4, 0, 1, 0,
                1, 0, 64'h0, 64'h0, 1);
    tbl[8] = mk(4'h9, 1, 3'b101, 3'b110, 32'h8000_0001, 32'h0, 64'h0, 64'h0, 2, 1, 1,
                0, 1, 64'h8000_0001_8000_0001, 64'h0, 6);

    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_unary = 1'b0; req_a_src = '0; req_b_src = '0;
    req_rs1 = '0; req_rs2 = '0; req_xs1 = '0; req_xs2 = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while the FPU holds off ready: fpu_valid must drop at once.
    v = tbl[0];
    v.rdy_dly = 20;
    start_req(v, "rst_issue");
    repeat (2) @(negedge clk);
    chk("rst_issue_valid_before", 64'(fpu_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_issue");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the first WAIT cycle; the done pulse that follows is stale.
    v = tbl[0];
    v.lat = 3;
    start_req(v, "rst_wait");
    repeat (3) @(negedge clk);
    chk("rst_wait_in_wait", 64'({fpu_valid, resp_valid, req_ready}), 64'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid || !req_ready || fpu_valid) bad = 1'b1;
    end
    chk("rst_wait_stale_done", 64'(bad), 64'd0);
    run_txn(tbl[0], "after_rst");

    for (int i = 0; i < 40; i++) run_txn(rand_vec(), $sformatf("rnd%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequences one FPU operation per request through the single shared FPU input mux.
- Accepts an operation with two operand-source codes and captures operands A then B by time-multiplexing the mux `src` / `rs_data` / `xs_data` inputs.
- Issues the operation to the FPU core with a valid/ready handshake, waits for completion and returns the result with a valid/ready handshake.
- Sits between decode/regfile read and the Q15 FPU core.

Parameters:
- WAIT_TIMEOUT, 255, maximum cycles spent in WAIT before aborting with an error.
- OP_W, 4, FPU opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accept; high only in IDLE.
- req_op  in  OP_W  FPU opcode.
- req_unary  in  1  op uses operand A only; B is forced to 0.
- req_a_src  in  3  operand A mux source code.
- req_b_src  in  3  operand B mux source code.
- req_rs1  in  32  general-register data for A.
- req_rs2  in  32  general-register data for B.
- req_xs1  in  64  XMM data for A.
- req_xs2  in  64  XMM data for B.
- mux_src  out  3  drives the mux `src`.
- mux_rs_data  out  32  drives the mux `rs_data`.
- mux_xs_data  out  64  drives the mux `xs_data`.
- mux_data  in  64  mux output (combinational).
- fpu_valid  out  1  operation presented to the FPU.
- fpu_ready  in  1  FPU accepts the operation.
- fpu_op  out  OP_W  opcode to the FPU.
- fpu_a  out  64  Q15 operand A.
- fpu_b  out  64  Q15 operand B.
- fpu_done  in  1  one-cycle pulse; result valid.
- fpu_result  in  64  FPU result.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_data  out  64  result.
- resp_err  out  1  illegal source code or timeout.

Behaviour:
- States: IDLE, SEL_A, SEL_B, ISSUE, WAIT, RESP.
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - All latched fields and the timeout counter cleared.
- Reset mid-operation: the in-flight request is dropped; fpu_valid and resp_valid fall immediately (asynchronously). Any later fpu_done is ignored.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch op, unary, both src codes, rs1/rs2 and xs1/xs2.
  - If a_src>3'b101, or (!unary && b_src>3'b101): go to RESP with resp_err=1, resp_data=0. No FPU issue.
  - Otherwise go to SEL_A.
- SEL_A (1 cycle):
  - mux_src=a_src_q, mux_rs_data=rs1_q, mux_xs_data=xs1_q.
  - Register fpu_a<=mux_data at the clock edge.
  - Next state is SEL_B, or ISSUE if unary (which sets fpu_b<=0).
- SEL_B (1 cycle):
  - mux_src=b_src_q, mux_rs_data=rs2_q, mux_xs_data=xs2_q.
  - Register fpu_b<=mux_data. Next state is ISSUE.
- mux_src, mux_rs_data and mux_xs_data are 0 in all states other than SEL_A/SEL_B.
- ISSUE:
  - fpu_valid=1; fpu_op, fpu_a, fpu_b are held stable until fpu_valid && fpu_ready.
  - Then go to WAIT and clear the counter.
  - fpu_valid is never withdrawn before acceptance.
- WAIT:
  - On fpu_done: resp_data<=fpu_result, resp_err<=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches WAIT_TIMEOUT: resp_err<=1, resp_data<=0, go to RESP.
  - If fpu_done and timeout occur in the same cycle, fpu_done wins.
  - fpu_done in any state other than WAIT is ignored. The FPU guarantees at least 1 cycle of latency after acceptance.
- RESP:
  - resp_valid=1; resp_data and resp_err are stable until resp_ready.
  - On handshake go to IDLE.
  - req_ready stays 0 in RESP; there is no back-to-back accept, so at most one request is in flight.
- Best-case latency from accept to resp_valid is 4 + FPU latency cycles:
  - binary: SEL_A, SEL_B, ISSUE with fpu_ready=1, then WAIT.
  - unary: one cycle less.
- Counter width is clog2(WAIT_TIMEOUT+1). The counter saturates and does not wrap.

Test Plan:
- Binary op, a_src=3'b001, b_src=3'b000, fpu_ready=1, done 2 cycles after issue:
  - fpu_a=64'h0001_0000_0000_0000, fpu_b=0.
  - mux_src is 001 then 000 on consecutive cycles.
  - resp_valid rises exactly 6 cycles after accept, with resp_data=fpu_result.
- Unary op, a_src=3'b010, xs1=64'h0000_8000_0000_0000, b_src=3'b111:
  - no error; SEL_B is skipped; fpu_b=0.
  - fpu_a=64'h0000_8000_0000_0000.
- Illegal source, a_src=3'b110:
  - resp_valid one cycle after accept, resp_err=1, resp_data=0.
  - fpu_valid never asserted.
- fpu_ready held low 5 cycles, then resp_ready held low 3 cycles:
  - fpu_a, fpu_b, fpu_op stable throughout ISSUE.
  - resp_data stable throughout RESP.
  - req_ready=0 until the response handshake.
- WAIT_TIMEOUT=4, fpu_done never arrives:
  - resp_err=1 after 4 WAIT cycles.
  - A fpu_done pulse arriving later is ignored; the next request completes normally.
- rst_n pulsed low during WAIT:
  - all outputs return to reset values immediately; req_ready=1.
  - a stale fpu_done after reset produces no resp_valid.
